dm_arbiter: RTL and testbench



---
 rtl/sisc_mem_pkg.sv | 22 ++
 rtl/dm_wait_cnt.sv | 47 ++++
 rtl/dm_arbiter.sv | 153 +++++++++++++++
 tb/tb_dm_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_mem_pkg.sv
// Shared definitions for the SISC data-memory arbitration slice:
// state and owner encodings plus default bus widths.
package sisc_mem_pkg;

    localparam int unsigned AW_DEF       = 16;
    localparam int unsigned DW_DEF       = 32;
    localparam int unsigned MAX_WAIT_DEF = 4;
    // Wide enough for the largest legal starvation bound (15).
    localparam int unsigned WAIT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

endpackage

// File: rtl/dm_wait_cnt.sv
// Saturating starvation counter for the external port.
// Ports:
//   clk, rst_f  clock, asynchronous active-low reset
//   inc_i       count one CPU grant that bypassed a pending ext request
//   clr_i       clear (has priority over inc_i)
//   at_max_o    counter has reached MAX_WAIT (registered)
module dm_wait_cnt
    import sisc_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_f,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              at_max_q, at_max_d;

    // Next count; at_max is computed from the next value so it stays registered.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
        at_max_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cnt_q    <= '0;
            at_max_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            at_max_q <= at_max_d;
        end
    end

    assign at_max_o = at_max_q;

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the single-port synchronous data memory between the CPU
// datapath and an external requester. CPU has priority; the external port
// is forced to win after MAX_WAIT consecutive bypasses.
// Ports:
//   clk, rst_f                         clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_rdata   CPU request side, cpu_ack one-cycle pulse
//   cpu_stall                          cpu_req && !cpu_ack (combinational)
//   ext_req/we/addr/wdata, ext_rdata   external request side, ext_ack pulse
//   mem_en/we/addr/wdata, mem_rdata    memory side, 1-cycle read latency
module dm_arbiter
    import sisc_mem_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ext_ack_q, ext_ack_d;
    logic          wc_inc, wc_clr, wc_at_max;

    dm_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk      (clk),
        .rst_f    (rst_f),
        .inc_i    (wc_inc),
        .clr_i    (wc_clr),
        .at_max_o (wc_at_max)
    );

    // Next-state and registered-output logic. Memory controls are loaded on
    // the grant edge so they are valid for exactly the ACCESS cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cpu_ack_d   = 1'b0;
        ext_ack_d   = 1'b0;
        wc_inc      = 1'b0;
        wc_clr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ext_req && (!cpu_req || wc_at_max)) begin
                    state_d     = ACCESS;
                    owner_d     = OWN_EXT;
                    we_d        = ext_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = ext_we;
                    mem_addr_d  = ext_addr;
                    mem_wdata_d = ext_wdata;
                    wc_clr      = 1'b1;
                end else if (cpu_req) begin
                    state_d     = ACCESS;
                    owner_d     = OWN_CPU;
                    we_d        = cpu_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    // Count a bypass only when ext is actually waiting.
                    wc_inc      = ext_req;
                    wc_clr      = !ext_req;
                end else begin
                    // Both idle: ext_req is low here.
                    wc_clr = 1'b1;
                end
            end
            ACCESS: begin
                state_d   = RESP;
                cpu_ack_d = (owner_q == OWN_CPU);
                ext_ack_d = (owner_q == OWN_EXT);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ext_ack_q   <= ext_ack_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ext_ack   = ext_ack_q;

    // Read data arrives from memory in the ack cycle itself, so it is gated
    // rather than registered; writes return zero.
    assign cpu_rdata = (cpu_ack_q && !we_q) ? mem_rdata : '0;
    assign ext_rdata = (ext_ack_q && !we_q) ? mem_rdata : '0;
    assign cpu_stall = cpu_req && !cpu_ack_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-level model checked every cycle plus
// directed literal expectations at fixed cycles.
module tb_dm_arbiter;

    localparam int unsigned AW       = 16;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_WAIT = 4;

    localparam int S_CACK  = 0;
    localparam int S_CRD   = 1;
    localparam int S_EACK  = 2;
    localparam int S_ERD   = 3;
    localparam int S_MEN   = 4;
    localparam int S_MWE   = 5;
    localparam int S_MADDR = 6;
    localparam int S_STALL = 7;
    localparam int S_MWD   = 8;

    logic          clk       = 1'b0;
    logic          rst_f     = 1'b0;
    logic          cpu_req   = 1'b0;
    logic          cpu_we    = 1'b0;
    logic [AW-1:0] cpu_addr  = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;
    logic          ext_req   = 1'b0;
    logic          ext_we    = 1'b0;
    logic [AW-1:0] ext_addr  = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic [DW-1:0] ext_rdata;
    logic          ext_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    dm_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory, 1-cycle read latency; 0x10 preloaded in reset.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (!rst_f) ram[8'h10] <= 32'hDEADBEEF;
        if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
    end

    // Directed expectations: (cycle, signal, literal value, name).
    int            dq_at  [$];
    int            dq_sel [$];
    logic [DW-1:0] dq_val [$];
    string         dq_nm  [$];
    int            to_cnt = 0;

    task automatic expect_at(input int at, input int sel, input logic [DW-1:0] val, input string nm);
        dq_at.push_back(at);
        dq_sel.push_back(sel);
        dq_val.push_back(val);
        dq_nm.push_back(nm);
    endtask

    function automatic logic [DW-1:0] pick(input int s);
        case (s)
            S_CACK:  pick = DW'(cpu_ack);
            S_CRD:   pick = cpu_rdata;
            S_EACK:  pick = DW'(ext_ack);
            S_ERD:   pick = ext_rdata;
            S_MEN:   pick = DW'(mem_en);
            S_MWE:   pick = DW'(mem_we);
            S_MADDR: pick = DW'(mem_addr);
            S_STALL: pick = DW'(cpu_stall);
            default: pick = mem_wdata;
        endcase
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: a grant made in cycle g gives the access in g+1,
    // the ack in g+2, and the next arbitration no earlier than g+3.
    int            g_cyc  = -100;
    logic          g_own  = 1'b0;   // 0 = CPU, 1 = external
    logic          g_we   = 1'b0;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_wd   = '0;
    logic [DW-1:0] g_rd   = '0;
    int            starve = 0;
    int            to_seen = 0;
    logic [DW-1:0] ref_mem [256] = '{default: '0};

    always @(negedge clk) begin
        logic acc, ack, e_c, e_e;
        if (!rst_f) begin
            g_cyc  = -100;
            starve = 0;
            ref_mem[16] = 32'hDEADBEEF;
            acc = 1'b0;
            ack = 1'b0;
        end else begin
            acc = (cyc == g_cyc + 1);
            ack = (cyc == g_cyc + 2);
        end
        e_c = ack && !g_own;
        e_e = ack && g_own;

        chk("mem_en",    DW'(mem_en),    DW'(acc));
        chk("mem_we",    DW'(mem_we),    DW'(acc && g_we));
        chk("mem_addr",  DW'(mem_addr),  acc ? DW'(g_addr) : '0);
        chk("mem_wdata", mem_wdata,      acc ? g_wd : '0);
        chk("cpu_ack",   DW'(cpu_ack),   DW'(e_c));
        chk("ext_ack",   DW'(ext_ack),   DW'(e_e));
        chk("cpu_rdata", cpu_rdata,      (e_c && !g_we) ? g_rd : '0);
        chk("ext_rdata", ext_rdata,      (e_e && !g_we) ? g_rd : '0);
        chk("cpu_stall", DW'(cpu_stall), DW'(cpu_req && !e_c));

        for (int i = 0; i < dq_at.size(); i++) begin
            if (dq_at[i] == cyc) chk(dq_nm[i], pick(dq_sel[i]), dq_val[i]);
        end

        n_checks++;
        if (to_cnt != to_seen) begin
            n_fail++;
            $display("FAIL handshake_timeout: actual %0d expired waits, required 0", to_cnt);
            to_seen = to_cnt;
        end

        if (rst_f && (cyc >= g_cyc + 3)) begin
            if (ext_req && (!cpu_req || starve >= int'(MAX_WAIT))) begin
                g_cyc = cyc; g_own = 1'b1; g_we = ext_we; g_addr = ext_addr; g_wd = ext_wdata;
                starve = 0;
            end else if (cpu_req) begin
                g_cyc = cyc; g_own = 1'b0; g_we = cpu_we; g_addr = cpu_addr; g_wd = cpu_wdata;
                if (!ext_req) starve = 0;
                else if (starve < int'(MAX_WAIT)) starve = starve + 1;
            end else begin
                starve = 0;
            end
            if (g_cyc == cyc) begin
                if (g_we) begin
                    ref_mem[g_addr[7:0]] = g_wd;
                    g_rd = '0;
                end else begin
                    g_rd = ref_mem[g_addr[7:0]];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_do(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic hold);
        bit seen = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = cpu_ack;
        end
        if (!seen) to_cnt++;
        step();
        if (!hold) cpu_req = 1'b0;
    endtask

    task automatic ext_do(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit seen = 1'b0;
        ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = ext_ack;
        end
        if (!seen) to_cnt++;
        step();
        ext_req = 1'b0;
    endtask

    initial begin
        int t0;
        // Reset: outputs zero, stall follows cpu_req.
        step();
        cpu_req = 1'b1;
        expect_at(cyc, S_STALL, 1, "rst_stall_follows_req");
        expect_at(cyc, S_CACK,  0, "rst_cpu_ack");
        expect_at(cyc, S_MEN,   0, "rst_mem_en");
        step();
        cpu_req = 1'b0;
        expect_at(cyc, S_STALL, 0, "rst_stall_low");
        step();
        rst_f = 1'b1;
        step();

        // 1: CPU read of preloaded word.
        t0 = cyc;
        expect_at(t0,     S_STALL, 1,            "t1_stall_c0");
        expect_at(t0,     S_MEN,   0,            "t1_men_c0");
        expect_at(t0 + 1, S_MEN,   1,            "t1_men_c1");
        expect_at(t0 + 1, S_MADDR, 32'h10,       "t1_addr_c1");
        expect_at(t0 + 1, S_STALL, 1,            "t1_stall_c1");
        expect_at(t0 + 2, S_CACK,  1,            "t1_ack_c2");
        expect_at(t0 + 2, S_CRD,   32'hDEADBEEF, "t1_rdata_c2");
        expect_at(t0 + 2, S_EACK,  0,            "t1_ext_ack");
        expect_at(t0 + 2, S_STALL, 0,            "t1_stall_c2");
        cpu_do(1'b0, 16'h0010, '0, 1'b0);

        // 2: ext write then CPU read-back.
        t0 = cyc;
        expect_at(t0 + 1, S_MWE,  1,            "t2_ext_we");
        expect_at(t0 + 1, S_MWD,  32'h12345678, "t2_ext_wdata");
        expect_at(t0 + 2, S_EACK, 1,            "t2_ext_ack");
        expect_at(t0 + 2, S_ERD,  0,            "t2_ext_rdata");
        expect_at(t0 + 5, S_CACK, 1,            "t2_cpu_ack");
        expect_at(t0 + 5, S_CRD,  32'h12345678, "t2_cpu_rdata");
        ext_do(1'b1, 16'h0020, 32'h12345678);
        cpu_do(1'b0, 16'h0020, '0, 1'b0);

        // 3: simultaneous requests, CPU wins.
        t0 = cyc;
        expect_at(t0 + 2, S_CACK, 1,            "t3_cpu_first");
        expect_at(t0 + 2, S_EACK, 0,            "t3_ext_not_first");
        expect_at(t0 + 5, S_EACK, 1,            "t3_ext_second");
        expect_at(t0 + 5, S_ERD,  32'h12345678, "t3_ext_rdata");
        fork
            cpu_do(1'b0, 16'h0010, '0, 1'b0);
            ext_do(1'b0, 16'h0020, '0);
        join

        // 4: starvation bound, ext wins after MAX_WAIT CPU grants.
        t0 = cyc;
        for (int i = 0; i < 4; i++) expect_at(t0 + 2 + 3 * i, S_CACK, 1, "t4_cpu_ack_n");
        expect_at(t0 + 11, S_EACK,  0,            "t4_ext_waits");
        expect_at(t0 + 13, S_MADDR, 32'h10,       "t4_ext_addr");
        expect_at(t0 + 14, S_EACK,  1,            "t4_ext_forced");
        expect_at(t0 + 14, S_ERD,   32'hDEADBEEF, "t4_ext_rdata");
        expect_at(t0 + 14, S_STALL, 1,            "t4_cpu_stalled");
        expect_at(t0 + 17, S_CACK,  1,            "t4_cpu_fifth");
        fork
            ext_do(1'b0, 16'h0010, '0);
            for (int i = 0; i < 5; i++) cpu_do(1'b0, 16'h0020, '0, (i < 4));
        join

        // Counter cleared: simultaneous requests go to the CPU again.
        t0 = cyc;
        expect_at(t0 + 2, S_CACK, 1, "t4_cnt_cleared_cpu");
        expect_at(t0 + 5, S_EACK, 1, "t4_cnt_cleared_ext");
        fork
            cpu_do(1'b0, 16'h0010, '0, 1'b0);
            ext_do(1'b0, 16'h0020, '0);
        join

        // 5: reset during the ACCESS cycle of a CPU write.
        t0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 32'hCAFEF00D;
        step();
        #1;
        rst_f = 1'b0;
        cpu_req = 1'b0;
        expect_at(t0 + 1, S_MEN,  0, "t5_men_drop");
        expect_at(t0 + 1, S_MWE,  0, "t5_mwe_drop");
        expect_at(t0 + 2, S_CACK, 0, "t5_no_ack");
        step();
        #1;
        rst_f = 1'b1;
        step();
        t0 = cyc;
        expect_at(t0 + 1, S_MWE,  1, "t5_reissue_we");
        expect_at(t0 + 2, S_CACK, 1, "t5_reissue_ack");
        expect_at(t0 + 2, S_CRD,  0, "t5_reissue_rdata");
        cpu_do(1'b1, 16'h0040, 32'hCAFEF00D, 1'b0);

        // 6: CPU write returns zero data, read-back returns the word.
        t0 = cyc;
        expect_at(t0 + 2, S_CACK, 1, "t6_wr_ack");
        expect_at(t0 + 2, S_CRD,  0, "t6_wr_rdata");
        cpu_do(1'b1, 16'h0030, 32'hA5A5A5A5, 1'b0);
        t0 = cyc;
        expect_at(t0 + 2, S_CRD, 32'hA5A5A5A5, "t6_rd_rdata");
        cpu_do(1'b0, 16'h0030, '0, 1'b0);
        t0 = cyc;
        expect_at(t0 + 2, S_CRD, 32'hCAFEF00D, "t5_rd_back");
        cpu_do(1'b0, 16'h0040, '0, 1'b0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
